// File: rtl/fmac_ipcs_pkt_fifo_if.sv
// Write/read/status bundle of the IPCS packet FIFO.
interface fmac_ipcs_pkt_fifo_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned PTR   = 9
);
    logic               wrreq;
    logic [WIDTH-1:0]   data;
    logic               wr_eop;
    logic               wr_abort;
    logic               wrfull;
    logic               almost_full;
    logic [PTR:0]       wrusedw;
    logic               rdreq;
    logic [WIDTH-1:0]   q;
    logic               rdempty;
    logic               almost_empty;
    logic [PTR:0]       rdusedw;
    logic               err_clr;
    logic               ovf;
    logic               udf;

    // Producer/consumer side.
    modport master (
        output wrreq, data, wr_eop, wr_abort, rdreq, err_clr,
        input  wrfull, almost_full, wrusedw, q, rdempty, almost_empty, rdusedw, ovf, udf
    );

    // FIFO side.
    modport slave (
        input  wrreq, data, wr_eop, wr_abort, rdreq, err_clr,
        output wrfull, almost_full, wrusedw, q, rdempty, almost_empty, rdusedw, ovf, udf
    );
endinterface

// File: rtl/fmac_ipcs_pkt_fifo.sv
// Single-clock packet FIFO for the IPCS path: words become readable only once
// committed by wr_eop; wr_abort rewinds the write pointer to the last commit.
module fmac_ipcs_pkt_fifo #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned PTR       = 9,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned PKT_MODE  = 1,
    parameter int unsigned AF_THRESH = DEPTH - 8,
    parameter int unsigned AE_THRESH = 4
) (
    input  logic                    clk,
    input  logic                    reset_,
    fmac_ipcs_pkt_fifo_if.slave     bus
);
    localparam int unsigned CW = PTR + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    wr_ptr;
    logic [CW-1:0]    cm_ptr;
    logic [CW-1:0]    rd_ptr;
    logic [CW-1:0]    wr_ptr_nxt;
    logic [CW-1:0]    cm_ptr_nxt;
    logic [CW-1:0]    used_w;
    logic [CW-1:0]    used_r;
    logic [WIDTH-1:0] q_r;
    logic             ovf_r;
    logic             udf_r;
    logic             empty;
    logic             full;
    logic             abort_c;
    logic             wr_ok;
    logic             rd_ok;
    logic             ovf_set;
    logic             udf_set;

    // Occupancy and flags, derived from registered pointers only.
    assign used_w           = wr_ptr - rd_ptr;
    assign used_r           = cm_ptr - rd_ptr;
    assign full             = (used_w == DEPTH_C);
    assign bus.wrusedw      = used_w;
    assign bus.rdusedw      = used_r;
    assign bus.wrfull       = full;
    assign bus.almost_full  = (used_w >= AF_C);
    assign bus.almost_empty = (used_r <= AE_C);
    assign bus.rdempty      = empty;
    assign bus.q            = q_r;
    assign bus.ovf          = ovf_r;
    assign bus.udf          = udf_r;

    // Write/commit/abort decisions and next pointer values.
    always_comb begin
        abort_c    = (PKT_MODE != 0) && bus.wr_abort;
        wr_ok      = bus.wrreq && !full && !abort_c;
        ovf_set    = bus.wrreq && full && !abort_c;
        rd_ok      = bus.rdreq && !empty;
        udf_set    = bus.rdreq && empty;
        wr_ptr_nxt = abort_c ? cm_ptr : (wr_ptr + CW'(wr_ok));
        cm_ptr_nxt = cm_ptr;
        if (PKT_MODE == 0) begin
            cm_ptr_nxt = wr_ptr_nxt;
        end else if (!abort_c && bus.wr_eop) begin
            cm_ptr_nxt = wr_ptr_nxt;
        end
    end

    // Write-side pointers and sticky error flags.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            wr_ptr <= '0;
            cm_ptr <= '0;
            ovf_r  <= 1'b0;
            udf_r  <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            cm_ptr <= cm_ptr_nxt;
            ovf_r  <= ovf_set || (ovf_r && !bus.err_clr);
            udf_r  <= udf_set || (udf_r && !bus.err_clr);
        end
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[PTR-1:0]] <= bus.data;
        end
    end

    if (FWFT == 0) begin : g_std
        assign empty = (used_r == '0);

        // Standard read: q loads the head word on an accepted pop.
        always_ff @(posedge clk) begin
            if (!reset_) begin
                rd_ptr <= '0;
                q_r    <= '0;
            end else if (rd_ok) begin
                q_r    <= mem[rd_ptr[PTR-1:0]];
                rd_ptr <= rd_ptr + CW'(1);
            end
        end
    end else begin : g_fwft
        logic          q_valid;
        logic [CW-1:0] rd_ptr_inc;

        assign rd_ptr_inc = rd_ptr + CW'(1);
        assign empty      = !q_valid;

        // Fall-through read: q holds the word at rd_ptr whenever q_valid.
        always_ff @(posedge clk) begin
            if (!reset_) begin
                rd_ptr  <= '0;
                q_r     <= '0;
                q_valid <= 1'b0;
            end else if (rd_ok) begin
                rd_ptr <= rd_ptr_inc;
                if (used_r > CW'(1)) begin
                    q_r <= mem[rd_ptr_inc[PTR-1:0]];
                end else begin
                    q_valid <= 1'b0;
                end
            end else if (!q_valid && (used_r != '0)) begin
                q_r     <= mem[rd_ptr[PTR-1:0]];
                q_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fmac_ipcs_pkt_fifo.sv
// Bench for the IPCS packet FIFO: a standard-read instance (DEPTH 512) and a
// fall-through instance (DEPTH 16), each checked against a queue model.
module tb_fmac_ipcs_pkt_fifo;
    localparam int unsigned W  = 64;
    localparam int unsigned DA = 512;
    localparam int unsigned PA = 9;
    localparam int unsigned DB = 16;
    localparam int unsigned PB = 4;

    logic clk = 1'b0;
    logic reset_;
    always #5 clk = ~clk;

    fmac_ipcs_pkt_fifo_if #(.WIDTH(W), .PTR(PA)) bus_a ();
    fmac_ipcs_pkt_fifo_if #(.WIDTH(W), .PTR(PB)) bus_b ();

    fmac_ipcs_pkt_fifo #(
        .WIDTH(W), .DEPTH(DA), .PTR(PA), .FWFT(0), .PKT_MODE(1),
        .AF_THRESH(DA - 8), .AE_THRESH(4)
    ) u_dut_a (.clk(clk), .reset_(reset_), .bus(bus_a));

    fmac_ipcs_pkt_fifo #(
        .WIDTH(W), .DEPTH(DB), .PTR(PB), .FWFT(1), .PKT_MODE(1),
        .AF_THRESH(12), .AE_THRESH(4)
    ) u_dut_b (.clk(clk), .reset_(reset_), .bus(bus_b));

    int checks   = 0;
    int failures = 0;

    // Model: unpopped words (committed ones first) plus committed count.
    logic [63:0] mq[$];
    int          ncm;
    bit          m_ovf, m_udf, m_shown;
    logic [63:0] m_q;
    int          m_depth, m_af, m_ae;
    bit          m_fwft;
    bit          sel;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input bit wr, input logic [63:0] d, input bit eop, input bit ab,
                         input bit rd, input bit clr);
        bus_a.wrreq = wr && !sel;  bus_b.wrreq = wr && sel;
        bus_a.data  = d;           bus_b.data  = d;
        bus_a.wr_eop = eop && !sel; bus_b.wr_eop = eop && sel;
        bus_a.wr_abort = ab && !sel; bus_b.wr_abort = ab && sel;
        bus_a.rdreq = rd && !sel;  bus_b.rdreq = rd && sel;
        bus_a.err_clr = clr && !sel; bus_b.err_clr = clr && sel;
    endtask

    task automatic model_step(input bit rst_n, input bit wr, input logic [63:0] d, input bit eop,
                              input bit ab, input bit rd, input bit clr);
        int sz;
        int old_ncm;
        bit full;
        bit empty;
        bit rd_ok;
        bit new_ovf;
        bit new_udf;
        if (!rst_n) begin
            mq.delete();
            ncm = 0; m_ovf = 0; m_udf = 0; m_shown = 0; m_q = '0;
            return;
        end
        sz      = mq.size();
        old_ncm = ncm;
        full    = (sz == m_depth);
        empty   = m_fwft ? !m_shown : (ncm == 0);
        rd_ok   = rd && !empty;
        new_udf = rd && empty;
        new_ovf = wr && full && !ab;
        if (rd_ok) begin
            if (!m_fwft) m_q = mq[0];
            void'(mq.pop_front());
            ncm--;
        end
        if (ab) begin
            while (mq.size() > ncm) void'(mq.pop_back());
        end else begin
            if (wr && !full) mq.push_back(d);
            if (eop) ncm = mq.size();
        end
        m_ovf = new_ovf || (m_ovf && !clr);
        m_udf = new_udf || (m_udf && !clr);
        if (m_fwft) begin
            if (m_shown) begin
                if (rd_ok) m_shown = (old_ncm > 1);
            end else begin
                m_shown = (old_ncm > 0);
            end
        end
    endtask

    task automatic check_all();
        logic [63:0] o_wu, o_ru, o_q;
        logic        o_full, o_af, o_empty, o_ae, o_ovf, o_udf;
        bit          exp_empty;
        if (sel) begin
            o_wu = 64'(bus_b.wrusedw); o_ru = 64'(bus_b.rdusedw); o_q = bus_b.q;
            o_full = bus_b.wrfull; o_af = bus_b.almost_full; o_empty = bus_b.rdempty;
            o_ae = bus_b.almost_empty; o_ovf = bus_b.ovf; o_udf = bus_b.udf;
        end else begin
            o_wu = 64'(bus_a.wrusedw); o_ru = 64'(bus_a.rdusedw); o_q = bus_a.q;
            o_full = bus_a.wrfull; o_af = bus_a.almost_full; o_empty = bus_a.rdempty;
            o_ae = bus_a.almost_empty; o_ovf = bus_a.ovf; o_udf = bus_a.udf;
        end
        exp_empty = m_fwft ? !m_shown : (ncm == 0);
        chk("wrusedw", o_wu, 64'(mq.size()));
        chk("rdusedw", o_ru, 64'(ncm));
        chk("wrfull", 64'(o_full), 64'(mq.size() == m_depth));
        chk("almost_full", 64'(o_af), 64'(mq.size() >= m_af));
        chk("rdempty", 64'(o_empty), 64'(exp_empty));
        chk("almost_empty", 64'(o_ae), 64'(ncm <= m_ae));
        chk("ovf", 64'(o_ovf), 64'(m_ovf));
        chk("udf", 64'(o_udf), 64'(m_udf));
        if (!m_fwft) chk("q", o_q, m_q);
        else if (m_shown && mq.size() > 0) chk("q_fwft", o_q, mq[0]);
    endtask

    // One clock: drive at the falling edge, check after the next falling edge.
    task automatic cyc(input bit rst_n, input bit wr, input logic [63:0] d, input bit eop,
                       input bit ab, input bit rd, input bit clr);
        reset_ = rst_n;
        drive(wr, d, eop, ab, rd, clr);
        model_step(rst_n, wr, d, eop, ab, rd, clr);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, '0, 0, 0, 0, 0);
    endtask

    task automatic rand_run(input int n, input int wr_pct, input int rd_pct);
        for (int i = 0; i < n; i++) begin
            cyc(1, $urandom_range(99) < wr_pct, {$urandom, $urandom},
                $urandom_range(99) < 20, $urandom_range(99) < 5,
                $urandom_range(99) < rd_pct, $urandom_range(99) < 5);
        end
    endtask

    initial begin
        // Standard-read instance.
        sel = 0; m_fwft = 0; m_depth = DA; m_af = DA - 8; m_ae = 4;
        cyc(0, 0, '0, 0, 0, 0, 0);
        cyc(0, 0, '0, 0, 0, 0, 0);
        chk("reset_rdempty", 64'(bus_a.rdempty), 64'd1);
        chk("reset_q", bus_a.q, 64'd0);

        for (int i = 1; i <= 5; i++) cyc(1, 1, 64'(i), i == 5, 0, 0, 0);
        chk("commit_rdempty", 64'(bus_a.rdempty), 64'd0);
        for (int i = 1; i <= 5; i++) begin
            cyc(1, 0, '0, 0, 0, 1, 0);
            chk("first_pkt_q", bus_a.q, 64'(i));
        end
        idle(1);
        chk("drained_rdusedw", 64'(bus_a.rdusedw), 64'd0);

        for (int i = 0; i < 3; i++) cyc(1, 1, 64'(16 + i), 0, 0, 0, 0);
        chk("pre_abort_wrusedw", 64'(bus_a.wrusedw), 64'd3);
        cyc(1, 1, 64'hdead, 0, 1, 0, 0);
        chk("post_abort_wrusedw", 64'(bus_a.wrusedw), 64'd0);
        cyc(1, 1, 64'h21, 0, 0, 0, 0);
        cyc(1, 1, 64'h22, 1, 0, 0, 0);
        cyc(1, 0, '0, 0, 0, 1, 0);
        chk("abort_pkt_q0", bus_a.q, 64'h21);
        cyc(1, 0, '0, 0, 0, 1, 0);
        chk("abort_pkt_q1", bus_a.q, 64'h22);
        cyc(1, 0, '0, 0, 0, 1, 0);
        cyc(1, 0, '0, 0, 0, 0, 1);

        for (int i = 0; i < int'(DA); i++) cyc(1, 1, 64'(1000 + i), i == int'(DA) - 1, 0, 0, 0);
        chk("fill_wrfull", 64'(bus_a.wrfull), 64'd1);
        cyc(1, 1, 64'hbad, 1, 0, 0, 0);
        chk("fill_ovf", 64'(bus_a.ovf), 64'd1);
        chk("fill_wrusedw", 64'(bus_a.wrusedw), 64'(DA));
        cyc(1, 1, 64'hbad2, 1, 0, 1, 0);
        chk("full_rdwr_wrusedw", 64'(bus_a.wrusedw), 64'(DA - 1));
        cyc(1, 0, '0, 0, 0, 0, 1);
        for (int i = 0; i < int'(DA) - 1; i++) cyc(1, 0, '0, 0, 0, 1, 0);

        for (int i = 0; i < 10; i++) cyc(1, 1, 64'(5000 + i), 1, 0, 0, 0);
        for (int i = 10; i < 3 * int'(DA) + 10; i++) cyc(1, 1, 64'(5000 + i), 1, 0, 1, 0);
        chk("wrap_rdusedw", 64'(bus_a.rdusedw), 64'd10);
        chk("wrap_ovf", 64'(bus_a.ovf), 64'd0);

        rand_run(1500, 60, 50);
        rand_run(1500, 85, 15);
        rand_run(1500, 30, 70);

        cyc(0, 0, '0, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) cyc(1, 1, 64'(7000 + i), i == 99, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 64'(8000 + i), 0, 0, 0, 0);
        chk("pre_reset_wrusedw", 64'(bus_a.wrusedw), 64'd105);
        cyc(0, 1, 64'h1234, 0, 0, 1, 0);
        chk("midrst_wrusedw", 64'(bus_a.wrusedw), 64'd0);
        chk("midrst_rdempty", 64'(bus_a.rdempty), 64'd1);
        chk("midrst_q", bus_a.q, 64'd0);
        cyc(1, 0, '0, 0, 0, 1, 1);
        chk("clr_vs_udf", 64'(bus_a.udf), 64'd1);

        // Fall-through instance.
        sel = 1; m_fwft = 1; m_depth = DB; m_af = 12; m_ae = 4;
        cyc(0, 0, '0, 0, 0, 0, 0);
        cyc(1, 1, 64'hA, 0, 0, 0, 0);
        cyc(1, 1, 64'hB, 1, 0, 0, 0);
        chk("fwft_commit_edge_empty", 64'(bus_b.rdempty), 64'd1);
        idle(1);
        chk("fwft_head_q", bus_b.q, 64'hA);
        chk("fwft_head_empty", 64'(bus_b.rdempty), 64'd0);
        cyc(1, 0, '0, 0, 0, 1, 0);
        chk("fwft_next_q", bus_b.q, 64'hB);
        cyc(1, 0, '0, 0, 0, 1, 0);
        chk("fwft_drained", 64'(bus_b.rdempty), 64'd1);
        cyc(1, 0, '0, 0, 0, 1, 0);
        chk("fwft_udf", 64'(bus_b.udf), 64'd1);
        rand_run(1500, 60, 50);
        rand_run(1000, 85, 20);
        rand_run(1000, 30, 80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
